// File: rtl/trivium_pkg.sv
// Shared types and constants for the Trivium sequencing controller.
package trivium_pkg;

   localparam int TRIVIUM_KEY_W     = 80;
   localparam int TRIVIUM_IV_W      = 80;
   localparam int TRIVIUM_WARMUP    = 1152;
   localparam int TRIVIUM_CFG_BYTES = (TRIVIUM_KEY_W + TRIVIUM_IV_W) / 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_WARMUP = 2'd2,
      ST_RUN    = 2'd3
   } state_e;

endpackage

// File: rtl/trivium_ctrl_if.sv
// Byte-wide configuration input and keystream output handshakes.
// master = host side (supplies key/IV bytes, consumes keystream bytes).
// slave  = controller side.
interface trivium_ctrl_if;

   logic [7:0] cfg_data;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [7:0] ks_data;
   logic       ks_valid;
   logic       ks_ready;

   modport master (
      output cfg_data, cfg_valid, ks_ready,
      input  cfg_ready, ks_data, ks_valid
   );

   modport slave (
      input  cfg_data, cfg_valid, ks_ready,
      output cfg_ready, ks_data, ks_valid
   );

endinterface

// File: rtl/ks_byte_packer.sv
// Packs keystream bits into bytes, first bit in bit 7. Holds the core
// with seven bits pending while a finished byte is still unread.
module ks_byte_packer (
   input  logic       clk,
   input  logic       rst,      // synchronous clear (reset or abort)
   input  logic       i_run,    // controller is in RUN
   input  logic       i_bit,    // core output bit for the current step
   output logic       o_en,     // core may advance this cycle
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready
);

   // Seven pending bits; the eighth goes straight into the output byte.
   logic [6:0] r_col;
   logic [2:0] r_bitcnt;
   logic [7:0] r_data;
   logic       r_valid;
   logic       w_last;
   logic       w_stall;
   logic       w_en;

   assign w_last  = (r_bitcnt == 3'd7);
   assign w_stall = w_last && r_valid && !i_ready;
   assign w_en    = i_run && !w_stall;

   assign o_en    = w_en;
   assign o_data  = r_data;
   assign o_valid = r_valid;

   // Collect bits and publish a byte when its eighth bit arrives.
   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_col    <= '0;
         r_bitcnt <= '0;
         r_data   <= '0;
         r_valid  <= 1'b0;
      end else begin
         if (r_valid && i_ready) begin
            r_valid <= 1'b0;
         end
         if (w_en) begin
            r_col    <= {r_col[5:0], i_bit};
            r_bitcnt <= r_bitcnt + 3'd1;
            // A new byte overrides the drain above; the stall guarantees
            // the output register is empty or being read this cycle.
            if (w_last) begin
               r_data  <= {r_col, i_bit};
               r_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/trivium_ctrl.sv
// Sequencing controller for the Trivium core: byte-serial key/IV load,
// load strobe, fixed warm-up, then byte-packed keystream output.
module trivium_ctrl
   import trivium_pkg::*;
#(
   parameter int WARMUP_CYCLES = TRIVIUM_WARMUP,
   parameter int CFG_BYTES     = TRIVIUM_CFG_BYTES
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_abort,
   trivium_ctrl_if.slave            bus,
   output logic                     o_busy,
   output logic [1:0]               o_state,
   output logic [TRIVIUM_KEY_W-1:0] o_core_key,
   output logic [TRIVIUM_IV_W-1:0]  o_core_iv,
   output logic                     o_core_load,
   output logic                     o_core_en,
   input  logic                     i_core_ks_bit
);

   localparam int CHAIN_W = TRIVIUM_KEY_W + TRIVIUM_IV_W;
   localparam int WCW     = $clog2(WARMUP_CYCLES + 1);
   localparam int BCW     = $clog2(CFG_BYTES);
   localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP_CYCLES - 1);
   localparam logic [BCW-1:0] BYTE_LAST = BCW'(CFG_BYTES - 1);

   state_e               r_state;
   state_e               w_state_nxt;
   logic [BCW-1:0]       r_bytecnt;
   logic [WCW-1:0]       r_wcnt;
   logic [CHAIN_W-1:0]   r_chain;
   logic                 r_load;
   logic                 r_busy;
   logic                 w_clr;
   logic                 w_accept;
   logic                 w_last_byte;
   logic                 w_warm_done;
   logic                 w_pk_en;

   // Abort behaves exactly like reset and wins over everything else.
   assign w_clr       = rst | i_abort;
   assign bus.cfg_ready = (r_state == ST_IDLE);
   assign w_accept    = bus.cfg_valid && bus.cfg_ready;
   assign w_last_byte = w_accept && (r_bytecnt == BYTE_LAST);
   assign w_warm_done = (r_wcnt == WARM_LAST);

   assign o_state     = r_state;
   assign o_busy      = r_busy;
   assign o_core_load = r_load;
   assign o_core_key  = r_chain[CHAIN_W-1 -: TRIVIUM_KEY_W];
   assign o_core_iv   = r_chain[TRIVIUM_IV_W-1:0];
   assign o_core_en   = (r_state == ST_WARMUP) | w_pk_en;

   // State register.
   always_ff @(posedge clk) begin
      if (w_clr) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state decode.
   // NOTE: default assignment first, so no path leaves w_state_nxt unassigned (no latch).
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_last_byte) w_state_nxt = ST_LOAD;
         ST_LOAD:   w_state_nxt = ST_WARMUP;
         ST_WARMUP: if (w_warm_done) w_state_nxt = ST_RUN;
         ST_RUN:    w_state_nxt = ST_RUN;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Key/IV shift chain, MSB first: byte 0 ends at key[79:72], last byte at iv[7:0].
   // NOTE: the chain is cleared on reset because the core key/IV outputs must read zero.
   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_bytecnt <= '0;
         r_chain   <= '0;
      end else if (w_accept) begin
         r_chain   <= {r_chain[CHAIN_W-9:0], bus.cfg_data};
         r_bytecnt <= w_last_byte ? '0 : r_bytecnt + BCW'(1);
      end
   end

   // Warm-up step counter; sits at zero outside WARMUP.
   always_ff @(posedge clk) begin
      if (w_clr)                    r_wcnt <= '0;
      else if (r_state == ST_WARMUP) r_wcnt <= r_wcnt + WCW'(1);
      else                          r_wcnt <= '0;
   end

   // Registered load strobe and busy flag, decoded from the next state.
   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_load <= 1'b0;
         r_busy <= 1'b0;
      end else begin
         r_load <= (w_state_nxt == ST_LOAD);
         r_busy <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_WARMUP);
      end
   end

   ks_byte_packer u_packer (
      .clk     (clk),
      .rst     (w_clr),
      .i_run   (r_state == ST_RUN),
      .i_bit   (i_core_ks_bit),
      .o_en    (w_pk_en),
      .o_data  (bus.ks_data),
      .o_valid (bus.ks_valid),
      .i_ready (bus.ks_ready)
   );

endmodule
